uart_rx_cfg: RTL and testbench

Parametrised UART receiver. It replaces the fixed 8N1, tick-per-bit receiver with an oversampled front end. It adds:
- mid-bit sampling and false-start rejection;
- configurable data width, parity and stop bits;
- a ready/valid output with parity, framing and overrun reporting.

It sits between the pad-side serial input and the bridge's RX byte FIFO. Its baud tick comes from the shared baud generator.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_cfg.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Width of a counter that walks the sample ticks of one bit period.
  function automatic int tick_cnt_w(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin, with a configurable reset level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable width/parity/stop bits and a
// single-word ready/valid holding register with parity, framing and overrun reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int TICK_W = tick_cnt_w(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] PAR_MODE =
    (PARITY_EN == 0) ? PAR_NONE : ((PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN);
  localparam logic PAR_ODD_BIT = (PAR_MODE == PAR_ODD);

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (serial_in),
    .sync_out (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  done_q, done_d;

  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_par_err_q, rx_par_err_d;
  logic                  framing_error_q, framing_error_d;
  logic                  overrun_error_q, overrun_error_d;

  logic bit_end;
  assign bit_end = (tick_cnt_q == FULL_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

  // Frame flags are cleared on start detection; the completion logic of the
  // previous frame still sees the old values on that same edge.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;

    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d     = ST_START;
            tick_cnt_d  = '0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
          end
        end

        ST_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_err_d  = ((^shift_q) ^ rx_s) != PAR_ODD_BIT;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              frame_err_d = 1'b1;
            end
            // Leave at the last stop-bit centre so the next start edge is not missed.
            if (bit_cnt_q == STOP_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_par_err_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_par_err_q    <= rx_par_err_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  // A word read out on the completion edge frees the holding register for the new one.
  always_comb begin
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_par_err_d    = rx_par_err_q;
    framing_error_d = 1'b0;
    overrun_error_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (done_q) begin
      if (frame_err_q) begin
        framing_error_d = 1'b1;
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_par_err_d = par_err_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_error_d = 1'b1;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_par_err_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2)
// share clock and tick; each scenario drives one serial line at a time.
module tb_uart_rx_cfg;

  localparam int OS  = 16;
  localparam int CPB = OS;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic [2:0] ser;
  logic [2:0] rdy;
  bit         tick_half;

  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       pe0, pe1, pe2;
  logic       fe0, fe1, fe2;
  logic       ov0, ov1, ov2;
  logic       b0, b1, b2;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] exp_q [$];
  logic [10:0] got_q [$];
  int          got_rd = 0;
  int          fe_cnt [3] = '{0, 0, 0};
  int          ov_cnt [3] = '{0, 0, 0};

  always #5 clock = ~clock;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .serial_in(ser[0]),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy[0]), .rx_parity_err(pe0),
    .framing_error(fe0), .overrun_error(ov0), .busy(b0)
  );

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .serial_in(ser[1]),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy[1]), .rx_parity_err(pe1),
    .framing_error(fe1), .overrun_error(ov1), .busy(b1)
  );

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .serial_in(ser[2]),
    .rx_data(d2), .rx_valid(v2), .rx_ready(rdy[2]), .rx_parity_err(pe2),
    .framing_error(fe2), .overrun_error(ov2), .busy(b2)
  );

  // Tick runs every clock, or every other clock when tick_half is set.
  always @(posedge clock) begin
    #1;
    sample_tick = tick_half ? ~sample_tick : 1'b1;
  end

  // Monitor: capture every accepted word and count error pulses, away from the active edge.
  always @(negedge clock) begin
    if (v0 && rdy[0]) got_q.push_back({2'd0, pe0, d0});
    if (v1 && rdy[1]) got_q.push_back({2'd1, pe1, d1});
    if (v2 && rdy[2]) got_q.push_back({2'd2, pe2, d2});
    if (fe0) fe_cnt[0]++;
    if (fe1) fe_cnt[1]++;
    if (fe2) fe_cnt[2]++;
    if (ov0) ov_cnt[0]++;
    if (ov1) ov_cnt[1]++;
    if (ov2) ov_cnt[2]++;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tickClocks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic parErr(input logic [7:0] data, input logic pbit, input logic odd);
    return ((^data) ^ pbit) != odd;
  endfunction

  task automatic pushExp(input int d, input logic [7:0] data, input logic perr);
    exp_q.push_back({2'(d), perr, data});
  endtask

  // Drive one frame LSB first: start, data, optional parity, stop bits; line left idle high.
  task automatic applyStimulus(input int d, input logic [7:0] data, input bit has_par,
                               input logic par_bit, input int nstop, input logic [1:0] stop_vals,
                               input int cpb);
    ser[d] = 1'b0;
    tickClocks(cpb);
    for (int i = 0; i < 8; i++) begin
      ser[d] = data[i];
      tickClocks(cpb);
    end
    if (has_par) begin
      ser[d] = par_bit;
      tickClocks(cpb);
    end
    for (int i = 0; i < nstop; i++) begin
      ser[d] = stop_vals[i];
      tickClocks(cpb);
    end
    ser[d] = 1'b1;
  endtask

  // Drain the scoreboard: every expected word must appear in order, and nothing extra.
  task automatic checkOutput(input string tag);
    logic [10:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        checkValue(tag, 32'(got_q[got_rd]), 32'(e));
        got_rd++;
      end else begin
        checkValue({tag, "_missing"}, 32'hDEAD_BEEF, 32'(e));
      end
    end
    checkValue({tag, "_extra"}, 32'(got_q.size() - got_rd), 32'd0);
  endtask

  initial begin
    int  fe_base, ov_base;
    bit  found;

    tick_half   = 1'b0;
    sample_tick = 1'b1;
    reset       = 1'b1;
    ser         = 3'b111;
    rdy         = 3'b000;
    tickClocks(3);

    // Reset values.
    checkValue("rst_rx_data", 32'(d0), 32'd0);
    checkValue("rst_rx_valid", 32'(v0), 32'd0);
    checkValue("rst_parity_err", 32'(pe0), 32'd0);
    checkValue("rst_framing", 32'(fe0), 32'd0);
    checkValue("rst_overrun", 32'(ov0), 32'd0);
    checkValue("rst_busy", 32'({b2, b1, b0}), 32'd0);
    reset = 1'b0;
    tickClocks(5);

    // 8N1 frame 0xA5 with consumer ready.
    rdy = 3'b111;
    fe_base = fe_cnt[0];
    ov_base = ov_cnt[0];
    pushExp(0, 8'hA5, 1'b0);
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, CPB);
    tickClocks(4);
    checkOutput("a5_word");
    checkValue("a5_no_framing", 32'(fe_cnt[0] - fe_base), 32'd0);
    checkValue("a5_no_overrun", 32'(ov_cnt[0] - ov_base), 32'd0);

    // False start: line low for 6 ticks then high again.
    fe_base = fe_cnt[0];
    ser[0] = 1'b0;
    tickClocks(6);
    checkValue("false_start_busy_hi", 32'(b0), 32'd1);
    ser[0] = 1'b1;
    tickClocks(14);
    checkValue("false_start_busy_lo", 32'(b0), 32'd0);
    checkOutput("false_start");
    checkValue("false_start_no_framing", 32'(fe_cnt[0] - fe_base), 32'd0);

    // Even parity: 0x03 with parity 1 is an error, 0x07 with parity 1 and 0x03 with parity 0 are not.
    pushExp(1, 8'h03, parErr(8'h03, 1'b1, 1'b0));
    applyStimulus(1, 8'h03, 1'b1, 1'b1, 1, 2'b11, CPB);
    pushExp(1, 8'h07, parErr(8'h07, 1'b1, 1'b0));
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1, 2'b11, CPB);
    pushExp(1, 8'h03, parErr(8'h03, 1'b0, 1'b0));
    applyStimulus(1, 8'h03, 1'b1, 1'b0, 1, 2'b11, CPB);
    tickClocks(4);
    checkOutput("parity");

    // Two stop bits, second one low: framing pulse, no word.
    fe_base = fe_cnt[2];
    applyStimulus(2, 8'h5A, 1'b0, 1'b0, 2, 2'b01, CPB);
    tickClocks(30);
    checkValue("stop2_framing_pulse", 32'(fe_cnt[2] - fe_base), 32'd1);
    checkValue("stop2_valid_lo", 32'(v2), 32'd0);
    checkOutput("stop2_bad");
    fe_base = fe_cnt[2];
    pushExp(2, 8'h5A, 1'b0);
    applyStimulus(2, 8'h5A, 1'b0, 1'b0, 2, 2'b11, CPB);
    tickClocks(4);
    checkOutput("stop2_good");
    checkValue("stop2_good_no_framing", 32'(fe_cnt[2] - fe_base), 32'd0);

    // Back-to-back 0x11, 0x22 with consumer stalled: second frame overruns.
    rdy[0] = 1'b0;
    ov_base = ov_cnt[0];
    pushExp(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, CPB);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, CPB);
    tickClocks(4);
    checkValue("overrun_pulse", 32'(ov_cnt[0] - ov_base), 32'd1);
    checkValue("overrun_held_valid", 32'(v0), 32'd1);
    checkValue("overrun_held_data", 32'(d0), 32'h11);
    rdy[0] = 1'b1;
    tickClocks(3);
    checkOutput("overrun_drain");

    // Same pair, consumer ready exactly on the second completion cycle: no overrun.
    rdy[0] = 1'b0;
    ov_base = ov_cnt[0];
    found = 1'b0;
    pushExp(0, 8'h11, 1'b0);
    pushExp(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, CPB);
    fork
      applyStimulus(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, CPB);
      begin
        for (int i = 0; i < 60 && !b0; i++) tickClocks(1);
        for (int i = 0; i < 300 && b0; i++) tickClocks(1);
        if (!b0) begin
          rdy[0] = 1'b1;
          found  = 1'b1;
        end
      end
    join
    tickClocks(4);
    checkValue("sameclk_ready_found", 32'(found), 32'd1);
    checkOutput("sameclk_load");
    checkValue("sameclk_no_overrun", 32'(ov_cnt[0] - ov_base), 32'd0);
    checkValue("sameclk_valid_lo", 32'(v0), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x3C.
    rdy[0] = 1'b1;
    ser[0] = 1'b0;
    tickClocks(CPB);
    ser[0] = 1'b1;
    tickClocks(4 * CPB + CPB / 2);
    reset = 1'b1;
    tickClocks(3);
    checkValue("midreset_busy", 32'(b0), 32'd0);
    checkValue("midreset_valid", 32'(v0), 32'd0);
    reset = 1'b0;
    tickClocks(6 * CPB);
    checkOutput("midreset_stale");
    pushExp(0, 8'h3C, 1'b0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11, CPB);
    tickClocks(4);
    checkOutput("after_reset");

    // Tick at half the clock rate: one bit spans 2*OS clocks.
    tick_half = 1'b1;
    tickClocks(4);
    pushExp(0, 8'h96, 1'b0);
    applyStimulus(0, 8'h96, 1'b0, 1'b0, 1, 2'b11, 2 * CPB);
    tickClocks(8);
    checkOutput("half_tick");
    tick_half = 1'b0;
    tickClocks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
